// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational instruction
// memory and hands each word to decode through a one-entry valid/ready stage.
module fetch_controller #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter logic [3:0]  HALT_OPCODE = 4'h6
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    FAULT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        accept;
  logic        slot_free;
  logic        in_range;
  logic        is_halt;

  assign accept    = if_valid & if_ready;
  assign slot_free = ~if_valid | accept;
  assign in_range  = (pc < DEPTH);
  assign is_halt   = (imem_instr[31:28] == HALT_OPCODE);

  assign imem_addr = pc;
  assign halted    = (state == HALTED);
  assign fault     = (state == FAULT);

  // Redirect wins over everything; otherwise RUN refills a free slot and the
  // stopped states only let the output stage drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 32'h0;
      if_pc       <= 32'h0;
      state       <= RUN;
      fetch_count <= 32'h0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      if_valid <= 1'b0;
      state    <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (slot_free) begin
            if (in_range) begin
              if_instr <= imem_instr;
              if_pc    <= pc;
              if_valid <= 1'b1;
              if (fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
              end
              // The HALT word is delivered but the PC parks on it.
              if (is_halt) begin
                state <= HALTED;
              end else begin
                pc <= pc + 32'd1;
              end
            end else begin
              if_valid <= 1'b0;
              state    <= FAULT;
            end
          end
        end
        default: begin
          if (accept) begin
            if_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
